// File: rtl/pc_sequencer.sv
// Purpose : program-counter sequencer with RUN/HALT control and saturating statistics counters.
// Latency : next PC is combinational from the current PC and decoder strobes and is registered on each clock edge.
// Backpress: there is no handshake; HALT (syscall 10) freezes the PC and counters until a rising edge on go.
//
// Ports (all state changes on the rising edge of clk_i, synchronous active-high rst_i):
//   clk_i, rst_i            clock and synchronous reset
//   go_i                    resume button (level); only its rising edge is acted on
//   beq_i, bne_i            decoder branch strobes; alu_equal_i is the rs==rt compare
//   jr_i, jmp_i, jal_i      decoder jump strobes
//   syscall_i, v0_value_i   syscall strobe and $v0 service code (10 = halt)
//   imm16_i, target26_i     branch word offset and jump index from the instruction
//   rs_value_i              register rs, the JR target
//   pc_o, pc_plus4_o        current PC and PC+4 (link value for JAL)
//   run_o, halted_o         commit qualifier and HALT indicator
//   disp_strobe_o           single-cycle pulse for a non-halt syscall (display service)
//   cycle_cnt_o, jump_cnt_o, branch_cnt_o   saturating statistics counters
module pc_sequencer #(
    parameter int                     PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
    parameter int                     CNT_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  go_i,
    input  logic                  beq_i,
    input  logic                  bne_i,
    input  logic                  jr_i,
    input  logic                  jmp_i,
    input  logic                  jal_i,
    input  logic                  syscall_i,
    input  logic                  alu_equal_i,
    input  logic [15:0]           imm16_i,
    input  logic [25:0]           target26_i,
    input  logic [PC_WIDTH-1:0]   rs_value_i,
    input  logic [31:0]           v0_value_i,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [PC_WIDTH-1:0]   pc_plus4_o,
    output logic                  run_o,
    output logic                  halted_o,
    output logic                  disp_strobe_o,
    output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
    output logic [CNT_WIDTH-1:0]  jump_cnt_o,
    output logic [CNT_WIDTH-1:0]  branch_cnt_o
);

    // Two-state machine; kept as plain constants so older tools map it directly.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [31:0] SYS_EXIT = 32'd10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]           state_q,      state_d;
    logic [PC_WIDTH-1:0]  pc_q,         pc_d;
    logic                 go_q;
    logic [CNT_WIDTH-1:0] cycle_cnt_q,  cycle_cnt_d;
    logic [CNT_WIDTH-1:0] jump_cnt_q,   jump_cnt_d;
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;

    // ------------------------------------------------------------------
    // Combinational next-PC datapath
    // ------------------------------------------------------------------
    logic                 run;
    logic                 go_rise;
    logic                 sys_exit;
    logic                 is_jump;
    logic                 br_taken;
    logic [PC_WIDTH-1:0]  pc_plus4;
    logic [PC_WIDTH-1:0]  br_offset;
    logic [PC_WIDTH-1:0]  jr_target;
    logic [PC_WIDTH-1:0]  j_target;
    logic [PC_WIDTH-1:0]  next_pc;

    assign run      = (state_q == ST_RUN);
    assign go_rise  = go_i & ~go_q;
    assign sys_exit = syscall_i & (v0_value_i == SYS_EXIT);
    assign is_jump  = jr_i | jmp_i | jal_i;
    assign br_taken = (beq_i & alu_equal_i) | (bne_i & ~alu_equal_i);

    // Natural-width add: 0xFFFF_FFFC + 4 wraps to 0.
    assign pc_plus4  = pc_q + PC_WIDTH'(4);

    // Word offset, sign-extended and scaled to bytes.
    assign br_offset = {{(PC_WIDTH-18){imm16_i[15]}}, imm16_i, 2'b00};

    // Masking (rather than slicing) keeps every rs bit in the cone.
    assign jr_target = rs_value_i & ~PC_WIDTH'(3);

    // Region-relative jump: top nibble of the delay-slot-free PC+4.
    assign j_target  = {pc_plus4[PC_WIDTH-1:28], target26_i, 2'b00};

    // Decoder is one-hot; the priority below only matters for illegal combos.
    always_comb begin
        next_pc = pc_plus4;
        if (jr_i) begin
            next_pc = jr_target;
        end else if (jmp_i | jal_i) begin
            next_pc = j_target;
        end else if (br_taken) begin
            next_pc = pc_plus4 + br_offset;
        end
    end

    // ------------------------------------------------------------------
    // RUN/HALT machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_RUN: begin
                if (sys_exit) begin
                    // Park on the syscall so the resume can step past it.
                    state_d = ST_HALT;
                end else begin
                    pc_d = next_pc;
                end
            end
            default: begin
                if (go_rise) begin
                    state_d = ST_RUN;
                    pc_d    = pc_plus4;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating statistics counters (advance only while committing)
    // ------------------------------------------------------------------
    always_comb begin
        cycle_cnt_d  = cycle_cnt_q;
        jump_cnt_d   = jump_cnt_q;
        branch_cnt_d = branch_cnt_q;
        if (run) begin
            if (!(&cycle_cnt_q)) begin
                cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
            end
            if (is_jump && !(&jump_cnt_q)) begin
                jump_cnt_d = jump_cnt_q + CNT_WIDTH'(1);
            end
            if (br_taken && !(&branch_cnt_q)) begin
                branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers: reset wins over every other event, including a go edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            go_q         <= 1'b0;
            cycle_cnt_q  <= '0;
            jump_cnt_q   <= '0;
            branch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            go_q         <= go_i;
            cycle_cnt_q  <= cycle_cnt_d;
            jump_cnt_q   <= jump_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign run_o         = run;
    assign halted_o      = (state_q == ST_HALT);
    assign disp_strobe_o = run & syscall_i & (v0_value_i != SYS_EXIT);
    assign cycle_cnt_o   = cycle_cnt_q;
    assign jump_cnt_o    = jump_cnt_q;
    assign branch_cnt_o  = branch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : directed and randomized checking of pc_sequencer against an arithmetic reference model.
// Latency : one model step per clock; outputs sampled 1 time unit after each rising edge.
// Backpress: none; the bench drives the decoder strobes and go button directly.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, go, beq, bne, jr, jmp, jal, syscall, alu_equal;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_value, v0_value;

    logic [31:0] pc, pc_plus4, cycle_cnt, jump_cnt, branch_cnt;
    logic        run, halted, disp_strobe;

    logic [31:0] s_pc, s_pc_plus4;
    logic        s_run, s_halted, s_disp;
    logic [3:0]  s_cycle_cnt, s_jump_cnt, s_branch_cnt;

    pc_sequencer u_dut (
        .clk_i(clk), .rst_i(rst), .go_i(go), .beq_i(beq), .bne_i(bne), .jr_i(jr),
        .jmp_i(jmp), .jal_i(jal), .syscall_i(syscall), .alu_equal_i(alu_equal),
        .imm16_i(imm16), .target26_i(target26), .rs_value_i(rs_value), .v0_value_i(v0_value),
        .pc_o(pc), .pc_plus4_o(pc_plus4), .run_o(run), .halted_o(halted),
        .disp_strobe_o(disp_strobe), .cycle_cnt_o(cycle_cnt), .jump_cnt_o(jump_cnt),
        .branch_cnt_o(branch_cnt)
    );

    // Narrow-counter build sharing the same stimulus, to exercise saturation.
    pc_sequencer #(.CNT_WIDTH(4)) u_sat (
        .clk_i(clk), .rst_i(rst), .go_i(go), .beq_i(beq), .bne_i(bne), .jr_i(jr),
        .jmp_i(jmp), .jal_i(jal), .syscall_i(syscall), .alu_equal_i(alu_equal),
        .imm16_i(imm16), .target26_i(target26), .rs_value_i(rs_value), .v0_value_i(v0_value),
        .pc_o(s_pc), .pc_plus4_o(s_pc_plus4), .run_o(s_run), .halted_o(s_halted),
        .disp_strobe_o(s_disp), .cycle_cnt_o(s_cycle_cnt), .jump_cnt_o(s_jump_cnt),
        .branch_cnt_o(s_branch_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: plain PC value, halted flag, unbounded counts.
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_goq;
    int unsigned m_cyc, m_jmp, m_br;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat4(input int unsigned v);
        return (v > 15) ? 64'd15 : 64'(v);
    endfunction

    task automatic clear_ops();
        beq = 0; bne = 0; jr = 0; jmp = 0; jal = 0; syscall = 0;
        alu_equal = 0; imm16 = '0; target26 = '0; rs_value = '0; v0_value = '0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_halt = 0; m_goq = 0; m_cyc = 0; m_jmp = 0; m_br = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit rise, taken;
        int off;
        if (rst) begin
            model_reset();
            return;
        end
        rise  = go && !m_goq;
        m_goq = go;
        if (m_halt) begin
            if (rise) begin
                m_halt = 0;
                m_pc   = m_pc + 32'd4;
            end
            return;
        end
        taken = (beq && alu_equal) || (bne && !alu_equal);
        m_cyc++;
        if (jr || jmp || jal) m_jmp++;
        if (taken) m_br++;
        if (syscall && v0_value == 32'd10) begin
            m_halt = 1;
        end else if (jr) begin
            m_pc = rs_value & 32'hFFFF_FFFC;
        end else if (jmp || jal) begin
            m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(target26) * 4);
        end else if (taken) begin
            off  = $signed(imm16) * 4;
            m_pc = m_pc + 32'd4 + 32'(off);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_state(input string where);
        chk({where, ":pc"},       64'(pc),         64'(m_pc));
        chk({where, ":pc_plus4"}, 64'(pc_plus4),   64'(m_pc + 32'd4));
        chk({where, ":halted"},   64'(halted),     64'(m_halt));
        chk({where, ":run"},      64'(run),        64'(!m_halt));
        chk({where, ":cycle"},    64'(cycle_cnt),  64'(m_cyc));
        chk({where, ":jump"},     64'(jump_cnt),   64'(m_jmp));
        chk({where, ":branch"},   64'(branch_cnt), 64'(m_br));
        chk({where, ":s_pc"},     64'(s_pc),       64'(m_pc));
        chk({where, ":s_cycle"},  64'(s_cycle_cnt),  sat4(m_cyc));
        chk({where, ":s_jump"},   64'(s_jump_cnt),   sat4(m_jmp));
        chk({where, ":s_branch"}, 64'(s_branch_cnt), sat4(m_br));
    endtask

    // One clock: check combinational outputs against the model, then step.
    task automatic cycle();
        #1;
        chk("disp_strobe", 64'(disp_strobe),
            64'(!rst && !m_halt && syscall && v0_value != 32'd10) | 64'(rst && !m_halt && syscall && v0_value != 32'd10));
        model_step();
        @(posedge clk);
        #1;
        check_state("cyc");
    endtask

    int unsigned saved;
    int unsigned op;

    initial begin
        rst = 1; go = 0;
        clear_ops();

        // Reset for two cycles.
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;
        chk("rst_pc",       64'(pc),          64'h0);
        chk("rst_pc_plus4", 64'(pc_plus4),    64'h4);
        chk("rst_run",      64'(run),         64'h1);
        chk("rst_halted",   64'(halted),      64'h0);
        chk("rst_disp",     64'(disp_strobe), 64'h0);
        chk("rst_cnts",     64'(cycle_cnt | jump_cnt | branch_cnt), 64'h0);

        // Sequential fetch.
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("seq_pc", 64'(pc), 64'(i * 4));
        end
        chk("seq_cycle_cnt", 64'(cycle_cnt), 64'd4);

        // Branches around 0x40.
        jmp = 1; target26 = 26'h10; cycle(); clear_ops();
        chk("jmp_0x40", 64'(pc), 64'h40);
        beq = 1; alu_equal = 1; imm16 = 16'hFFFE; cycle(); clear_ops();
        chk("beq_taken_pc", 64'(pc), 64'h3C);
        chk("beq_taken_cnt", 64'(branch_cnt), 64'd1);
        jmp = 1; target26 = 26'h10; cycle(); clear_ops();
        beq = 1; alu_equal = 0; imm16 = 16'hFFFE; cycle(); clear_ops();
        chk("beq_not_taken_pc", 64'(pc), 64'h44);
        chk("beq_not_taken_cnt", 64'(branch_cnt), 64'd1);

        // Jumps.
        jr = 1; rs_value = 32'h1000_0010; cycle(); clear_ops();
        saved = jump_cnt;
        chk("jal_link", 64'(pc_plus4), 64'h1000_0014);
        jal = 1; target26 = 26'h0000100; cycle(); clear_ops();
        chk("jal_pc", 64'(pc), 64'h1000_0400);
        jr = 1; rs_value = 32'h0000_0123; cycle(); clear_ops();
        chk("jr_pc", 64'(pc), 64'h120);
        chk("jump_cnt_plus2", 64'(jump_cnt), 64'(saved + 2));

        // Halt, held go resumes only once, display syscall.
        jr = 1; rs_value = 32'h20; cycle(); clear_ops();
        syscall = 1; v0_value = 32'd10; cycle();
        chk("halt_halted", 64'(halted), 64'h1);
        chk("halt_run", 64'(run), 64'h0);
        chk("halt_pc", 64'(pc), 64'h20);
        saved = cycle_cnt;
        v0_value = 32'd1;
        repeat (3) cycle();
        chk("halt_cycle_frozen", 64'(cycle_cnt), 64'(saved));
        clear_ops();
        go = 1; cycle();
        chk("resume_pc", 64'(pc), 64'h24);
        chk("resume_run", 64'(run), 64'h1);
        syscall = 1; v0_value = 32'd10; cycle(); clear_ops();
        repeat (3) cycle();
        chk("held_go_stays_halted", 64'(halted), 64'h1);
        chk("held_go_pc", 64'(pc), 64'h24);
        go = 0; cycle();
        go = 1; cycle(); go = 0;
        chk("second_resume_pc", 64'(pc), 64'h28);
        syscall = 1; v0_value = 32'd1; #1;
        chk("disp_pulse", 64'(disp_strobe), 64'h1);
        cycle(); clear_ops(); #1;
        chk("disp_pulse_end", 64'(disp_strobe), 64'h0);
        chk("disp_pc", 64'(pc), 64'h2C);

        // Reset while halted with go rising in the same cycle.
        syscall = 1; v0_value = 32'd10; cycle(); clear_ops();
        rst = 1; go = 1; cycle(); rst = 0; go = 0;
        chk("rst_halt_pc", 64'(pc), 64'h0);
        chk("rst_halt_run", 64'(run), 64'h1);
        chk("rst_halt_cnt", 64'(cycle_cnt | jump_cnt | branch_cnt), 64'h0);

        // Randomized decoder traffic.
        for (int n = 0; n < 600; n++) begin
            clear_ops();
            op        = $urandom_range(0, 7);
            alu_equal = $urandom_range(0, 1);
            imm16     = 16'($urandom);
            target26  = 26'($urandom);
            rs_value  = $urandom;
            v0_value  = ($urandom_range(0, 2) == 0) ? 32'd10 : 32'($urandom_range(0, 12));
            case (op)
                1: beq = 1;
                2: bne = 1;
                3: jr  = 1;
                4: jmp = 1;
                5: jal = 1;
                6: syscall = 1;
                default: ;
            endcase
            go  = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0; go = 0; clear_ops();

        // Saturation of the 4-bit build from a clean reset.
        rst = 1; cycle(); rst = 0;
        jmp = 1;
        repeat (20) cycle();
        clear_ops();
        chk("sat_cycle_hold", 64'(s_cycle_cnt), 64'hF);
        chk("sat_jump_hold", 64'(s_jump_cnt), 64'hF);
        chk("wide_cycle", 64'(cycle_cnt), 64'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
